// File: rtl/demorgan_sweep_checker_if.sv
// Start/done handshake plus A/B stimulus and lhs/rhs response bundle for demorgan_sweep_checker.
// Optional fail_map member exists only when DEMORGAN_FAIL_LOG_EN is defined.
interface demorgan_sweep_checker_if #(
  parameter int N_PAIRS = 2,
  parameter int ERR_W   = 4
);
  logic               start;
  logic               a;
  logic               b;
  logic [N_PAIRS-1:0] lhs;
  logic [N_PAIRS-1:0] rhs;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [1:0]         first_fail;

`ifdef DEMORGAN_FAIL_LOG_EN
  logic [4*N_PAIRS-1:0] fail_map;

  modport master (
    output start, lhs, rhs,
    input  a, b, busy, done, pass, err_count, first_fail, fail_map
  );

  modport slave (
    input  start, lhs, rhs,
    output a, b, busy, done, pass, err_count, first_fail, fail_map
  );
`else
  modport master (
    output start, lhs, rhs,
    input  a, b, busy, done, pass, err_count, first_fail
  );

  modport slave (
    input  start, lhs, rhs,
    output a, b, busy, done, pass, err_count, first_fail
  );
`endif
endinterface

// File: rtl/demorgan_sweep_checker.sv
// Sweeps A/B through 00,01,10,11, samples lhs/rhs identity pairs after a settle time, reports pass/fail.
// Define DEMORGAN_FAIL_LOG_EN to add the per-vector, per-pair fail_map output.
//
// state     | meaning
// ST_IDLE   | waiting for start, a/b parked at 0
// ST_DRIVE  | a/b held for SETTLE_CYCLES cycles
// ST_SAMPLE | one cycle: compare lhs/rhs, advance vector or finish
// ST_DONE   | one-cycle done pulse, pass valid
module demorgan_sweep_checker #(
  parameter int N_PAIRS       = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  demorgan_sweep_checker_if.slave bus
);

  localparam int CNT_W = $clog2(N_PAIRS + 1);
  localparam int SUM_W = ERR_W + CNT_W;
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [SUM_W-1:0] ERR_MAX     = SUM_W'({ERR_W{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         vec_idx;
  logic [3:0]         settle_cnt;
  logic               a_q;
  logic               b_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_nxt;
  logic [1:0]         first_fail_q;
  logic [N_PAIRS-1:0] mism;
  logic [CNT_W-1:0]   mism_cnt;
  logic [SUM_W-1:0]   err_sum;
  logic               busy_c;
  logic               done_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        busy_c = 1'b1;
        if (settle_cnt == 4'd0) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy_c    = 1'b1;
        state_nxt = (vec_idx == 2'd3) ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // An X/Z on either side fails the equality test and lands in the mismatch branch.
  always_comb begin
    mism     = '0;
    mism_cnt = '0;
    for (int i = 0; i < N_PAIRS; i++) begin
      mism[i] = 1'b1;
      if ((bus.lhs[i] ^ bus.rhs[i]) == 1'b0) mism[i] = 1'b0;
      mism_cnt = mism_cnt + CNT_W'(mism[i]);
    end
    err_sum = SUM_W'(err_q) + SUM_W'(mism_cnt);
    err_nxt = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_idx      <= 2'd0;
      settle_cnt   <= 4'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_fail_q <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            vec_idx      <= 2'd0;
            settle_cnt   <= SETTLE_LOAD;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= 2'd0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        ST_SAMPLE: begin
          err_q <= err_nxt;
          if (err_q == '0 && mism != '0) first_fail_q <= vec_idx;
          if (vec_idx == 2'd3) begin
            pass_q <= (err_nxt == '0);
          end else begin
            vec_idx    <= vec_idx + 2'd1;
            a_q        <= (vec_idx + 2'd1) >> 1;
            b_q        <= ~vec_idx[0];
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_DONE: begin
          vec_idx <= 2'd0;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_fail_q;

`ifdef DEMORGAN_FAIL_LOG_EN
  logic [4*N_PAIRS-1:0] fail_map_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          fail_map_q <= '0;
    else if (state == ST_IDLE && bus.start) fail_map_q <= '0;
    else if (state == ST_SAMPLE)           fail_map_q[int'(vec_idx)*N_PAIRS +: N_PAIRS] <= mism;
  end

  assign bus.fail_map = fail_map_q;
`endif

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench for demorgan_sweep_checker: a small De Morgan device model with fault modes
// feeds two checker instances (SETTLE 1 / ERR_W 4 and SETTLE 3 / ERR_W 3).
module tb_demorgan_sweep_checker;

  localparam int NP = 2;
  localparam int S0 = 1;
  localparam int E0 = 4;
  localparam int S1 = 3;
  localparam int E1 = 3;

  typedef struct {
    int         sel;
    int         lat;
    logic [3:0] err;
    logic       pss;
    logic [1:0] ff;
    logic [7:0] fmap;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  demorgan_sweep_checker_if #(.N_PAIRS(NP), .ERR_W(E0)) bus0 ();
  demorgan_sweep_checker_if #(.N_PAIRS(NP), .ERR_W(E1)) bus1 ();

  demorgan_sweep_checker #(.N_PAIRS(NP), .SETTLE_CYCLES(S0), .ERR_W(E0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  demorgan_sweep_checker #(.N_PAIRS(NP), .SETTLE_CYCLES(S1), .ERR_W(E1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  // fault modes: 0 ideal, 1 rhs[0] stuck 1 on A=1/B=0, 2 lhs=11 rhs=00, 3 lhs inverted in first settle cycle
  int   mode0 = 0;
  int   mode1 = 0;
  logic [1:0] ab0_d, ab1_d;
  logic       busy0_d, busy1_d;
  logic       glitch0, glitch1;

  function automatic logic [2*NP-1:0] dev_out(input logic a, input logic b, input int mode,
                                              input logic glitch);
    logic [NP-1:0] l, r;
    l[0] = ~a & ~b;
    r[0] = ~(a | b);
    l[1] = ~(a & b);
    r[1] = ~a | ~b;
    case (mode)
      1: if (a && !b) r[0] = 1'b1;
      2: begin l = '1; r = '0; end
      3: if (glitch) l = ~l;
      default: ;
    endcase
    return {l, r};
  endfunction

  always @(posedge clk) begin
    ab0_d   <= {bus0.a, bus0.b};
    ab1_d   <= {bus1.a, bus1.b};
    busy0_d <= bus0.busy;
    busy1_d <= bus1.busy;
  end

  assign glitch0 = ({bus0.a, bus0.b} != ab0_d) || (bus0.busy && !busy0_d);
  assign glitch1 = ({bus1.a, bus1.b} != ab1_d) || (bus1.busy && !busy1_d);
  assign {bus0.lhs, bus0.rhs} = dev_out(bus0.a, bus0.b, mode0, glitch0);
  assign {bus1.lhs, bus1.rhs} = dev_out(bus1.a, bus1.b, mode1, glitch1);

  int         sel = 0;
  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [1:0] m_ff;
`ifdef DEMORGAN_FAIL_LOG_EN
  logic [7:0] m_fmap;
`endif

  always_comb begin
    if (sel == 1) begin
      m_a = bus1.a; m_b = bus1.b; m_busy = bus1.busy; m_done = bus1.done;
      m_pass = bus1.pass; m_err = 4'(bus1.err_count); m_ff = bus1.first_fail;
`ifdef DEMORGAN_FAIL_LOG_EN
      m_fmap = bus1.fail_map;
`endif
    end else begin
      m_a = bus0.a; m_b = bus0.b; m_busy = bus0.busy; m_done = bus0.done;
      m_pass = bus0.pass; m_err = 4'(bus0.err_count); m_ff = bus0.first_fail;
`ifdef DEMORGAN_FAIL_LOG_EN
      m_fmap = bus0.fail_map;
`endif
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic exp_t model_sweep(input int s, input int mode);
    exp_t       e;
    int         raw;
    int         emax;
    logic [1:0] mm;
    emax   = (s == 1) ? (1 << E1) - 1 : (1 << E0) - 1;
    e.sel  = s;
    e.lat  = 4 * (((s == 1) ? S1 : S0) + 1) + 1;
    e.ff   = 2'd0;
    e.fmap = 8'd0;
    raw    = 0;
    for (int v = 0; v < 4; v++) begin
      case (mode)
        1:       mm = (v == 2) ? 2'b01 : 2'b00;
        2:       mm = 2'b11;
        default: mm = 2'b00;
      endcase
      if (mm != 2'b00 && raw == 0) e.ff = 2'(v);
      raw += int'(mm[0]) + int'(mm[1]);
      e.fmap[v*NP +: NP] = mm;
    end
    e.err = (raw > emax) ? 4'(emax) : 4'(raw);
    e.pss = (raw == 0);
    return e;
  endfunction

  exp_t       sb[$];
  logic [1:0] ab_tr[$];
  int         cyc       = 0;
  int         start_cyc = 0;
  int         n_done    = 0;
  int         n_pushed  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t e;
    int   per;
    int   bad;
    forever begin
      @(negedge clk);
      if (m_busy) ab_tr.push_back({m_a, m_b});
      if (m_done) begin
        n_done++;
        chk_val("done_count", n_done, n_pushed);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          per = (e.lat - 1) / 4;
          chk_val("latency", cyc - start_cyc, e.lat);
          chk_val("err_count", int'(m_err), int'(e.err));
          chk_val("pass", int'(m_pass), int'(e.pss));
          if (!e.pss) chk_val("first_fail", int'(m_ff), int'(e.ff));
          chk_val("done_ab", int'({m_a, m_b}), 3);
`ifdef DEMORGAN_FAIL_LOG_EN
          chk_val("fail_map", int'(m_fmap), int'(e.fmap));
`endif
          bad = 0;
          foreach (ab_tr[i]) if (int'(ab_tr[i]) != i / per) bad++;
          chk_val("ab_len", ab_tr.size(), 4 * per);
          chk_val("ab_seq", bad, 0);
        end
      end
    end
  end

  task automatic drive_start(input int s, input logic v);
    if (s == 1) bus1.start = v;
    else        bus0.start = v;
  endtask

  task automatic check_idle(input string tag);
    chk_val({tag, "_a"},     int'(m_a), 0);
    chk_val({tag, "_b"},     int'(m_b), 0);
    chk_val({tag, "_busy"},  int'(m_busy), 0);
    chk_val({tag, "_done"},  int'(m_done), 0);
    chk_val({tag, "_pass"},  int'(m_pass), 0);
    chk_val({tag, "_err"},   int'(m_err), 0);
    chk_val({tag, "_ff"},    int'(m_ff), 0);
`ifdef DEMORGAN_FAIL_LOG_EN
    chk_val({tag, "_fmap"},  int'(m_fmap), 0);
`endif
  endtask

  task automatic run_sweep(input int s, input int mode, input bit repulse);
    exp_t e;
    int   base;
    sel = s;
    if (s == 1) mode1 = mode;
    else        mode0 = mode;
    e = model_sweep(s, mode);
    @(negedge clk);
    ab_tr.delete();
    sb.push_back(e);
    n_pushed++;
    start_cyc = cyc;
    base      = n_done;
    drive_start(s, 1'b1);
    @(negedge clk);
    drive_start(s, 1'b0);
    if (repulse) begin
      repeat (2) @(negedge clk);
      drive_start(s, 1'b1);
      @(negedge clk);
      drive_start(s, 1'b0);
    end
    for (int k = 0; k < 60 && n_done == base; k++) @(negedge clk);
    chk_val("done_seen", n_done - base, 1);
    repeat (repulse ? 14 : 3) @(negedge clk);
    chk_val("pass_hold", int'(m_pass), int'(e.pss));
    if (repulse) chk_val("single_done", n_done - base, 1);
  endtask

  task automatic reset_mid_sweep();
    int base;
    sel   = 0;
    mode0 = 2;
    @(negedge clk);
    ab_tr.delete();
    sb.push_back(model_sweep(0, 2));
    n_pushed++;
    start_cyc = cyc;
    base      = n_done;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (5) @(negedge clk);
    chk_val("err_before_rst", int'(m_err), 4);
    chk_val("busy_before_rst", int'(m_busy), 1);
    #1 reset_n = 1'b0;
    #1 check_idle("async_rst");
    sb.delete(sb.size() - 1);
    n_pushed--;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (14) @(negedge clk);
    chk_val("no_done_after_rst", n_done - base, 0);
    chk_val("idle_after_rst", int'(m_busy), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 0, 1'b0);
    run_sweep(0, 1, 1'b0);
    run_sweep(1, 2, 1'b0);
    run_sweep(0, 2, 1'b0);
    run_sweep(0, 0, 1'b1);
    reset_mid_sweep();
    run_sweep(0, 0, 1'b0);
    run_sweep(1, 3, 1'b0);
    run_sweep(1, 1, 1'b0);
    run_sweep(1, 0, 1'b0);

    chk_val("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
